pila_retorno: RTL and testbench
===============================

Name: pila_retorno

Overview:
- Hardware return-address stack (LIFO) directly upstream of the program counter, feeding the `s_stack` input of the PC source mux in the single-cycle datapath `cd`.
- On a call it captures the current PC and stores the return address (PC+1).
- On a return it presents that address so the PC loads it at the same clock edge.
- Adds depth parameterisation, occupancy reporting and sticky overflow/underflow error flags, so the control unit and a debug port can detect runaway recursion.

Parameters:
- AW, 10, address width; matches PC and program-memory address width.
- DEPTH, 8, number of stack entries; power of two, 2..64.
- PW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- popsignal  input  1  return: remove top entry this cycle.
- pushsignal  input  1  call: store push+1 this cycle.
- push  input  AW  current PC value, i.e. the address of the call instruction.
- pop  output  AW  top-of-stack return address; combinational from stored state.
- vacia  output  1  stack empty (nivel==0).
- llena  output  1  stack full (nivel==DEPTH).
- nivel  output  PW+1  number of valid entries, 0..DEPTH.
- desbordamiento  output  1  sticky overflow flag.
- subdesbordamiento  output  1  sticky underflow flag.

Behaviour:
- Reset (async, immediate):
  - sp=0, nivel=0, vacia=1, llena=0, both sticky flags=0, pop=0.
  - Entry storage is not cleared.
- Stored value: push+1 modulo 2^AW. A push of 10'h3FF stores 10'h000.
- pop output:
  - Equals entry[sp-1] when nivel>0, else 0.
  - Zero latency: valid in the same cycle `popsignal` is asserted, so `mux_stack` can route it into the PC at that edge.
- Push only (push=1, pop=0):
  - Not full: entry[sp] <= push+1; sp++ ; nivel++.
  - Full: behaviour depends on the optional feature below.
- Pop only (push=0, pop=1):
  - Not empty: sp-- ; nivel--.
  - Empty: no state change; subdesbordamiento <= 1; pop output stays 0.
- Both asserted (return immediately followed by call, tail replacement):
  - Not empty: entry[sp-1] <= push+1; sp and nivel unchanged; pop shows the old top during that cycle.
  - Empty: treated as push only; subdesbordamiento is not set.
- Neither asserted: hold all state.
- Sticky flags clear only on reset.
- State updates are registered; pop, vacia, llena and nivel reflect the new state from the cycle after the edge.
- Reset asserted mid-sequence aborts any push/pop in that cycle. After release the stack is empty.

Optional Feature:
- Macro: PILA_CIRCULAR_EN.
- Defined, push on full:
  - Overwrites the oldest entry (circular buffer).
  - Write goes to entry[sp]; sp wraps modulo DEPTH; nivel stays DEPTH.
  - desbordamiento <= 1.
  - After DEPTH pops the stack reads empty; the overwritten frames are lost.
- Undefined, push on full:
  - Push is dropped; no storage, sp or nivel change.
  - desbordamiento <= 1.
- With the macro defined, sp and the base index are tracked modulo DEPTH; nivel saturates at DEPTH.

Decomposition:
- Shared package (constants include) holds:
  - PC_AW=10;
  - default stack depth 8;
  - the return-address increment constant 1, shared with the PC adder `sum`.
- No sub-module is needed. Storage is a plain register array in this module, in the style of `regfile`.
- `cd` replaces its `stack` instance with `pila_retorno` and wires the flags to the control unit or debug outputs.

Test Plan:
1. Reset, then push=10'h010 with pushsignal=1 for 1 cycle → nivel=1, vacia=0, pop=10'h011.
2. Push 10'h020, 10'h030, 10'h040, then pop 3 times → pop shows 041, 031, 021 in the pop cycles; nivel ends at 0; vacia=1.
3. Pop on empty → subdesbordamiento=1, nivel=0, pop=0. The flag stays 1 after 5 idle cycles and clears only on reset.
4. Push 10'h3FF → pop=10'h000 (wrap of the +1).
5. Fill 8 entries (values 0..7, stored 1..8), then push 10'h100:
   - Without macro: llena=1, desbordamiento=1, pop=8, 8 pops return 8..1.
   - With macro: pop=10'h101; 8 pops return 101, 8, 7, 6, 5, 4, 3, 2.
6. With nivel=2 (top 10'h051), assert push=10'h060 and popsignal=pushsignal=1 → pop=10'h051 that cycle, then pop=10'h061 with nivel=2. Then assert reset mid-cycle → nivel=0, pop=0 immediately.

Source files
------------

// File: rtl/pila_retorno_pkg.sv
// Shared constants for the return-address stack and the PC datapath.
package pila_retorno_pkg;
   localparam int PC_AW       = 10;  // PC and program-memory address width
   localparam int STACK_DEPTH = 8;   // default number of stack entries
   localparam int RET_INC     = 1;   // return-address increment, shared with the PC adder
endpackage

// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) feeding the PC source mux, with occupancy and sticky error flags.
// Define PILA_CIRCULAR_EN to make a push on full overwrite the oldest entry instead of dropping it.
module pila_retorno
   import pila_retorno_pkg::*;
#(
   parameter int AW    = PC_AW,
   parameter int DEPTH = STACK_DEPTH,
   parameter int PW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          popsignal,
   input  logic          pushsignal,
   input  logic [AW-1:0] push,
   output logic [AW-1:0] pop,
   output logic          vacia,
   output logic          llena,
   output logic [PW:0]   nivel,
   output logic          desbordamiento,
   output logic          subdesbordamiento
);

   logic [AW-1:0] mem_q [DEPTH];
   logic [PW-1:0] sp_q, sp_d;
   logic [PW:0]   nivel_q, nivel_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic          wr_en;
   logic [PW-1:0] wr_idx;
   logic [AW-1:0] wr_data;
   logic [PW-1:0] top_idx;
   logic          empty, full;

   // sp always points one past the top, so the top wraps naturally modulo DEPTH
   assign top_idx = sp_q - PW'(1);
   assign empty   = (nivel_q == '0);
   assign full    = (nivel_q == (PW+1)'(DEPTH));

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      sp_d    = sp_q;
      nivel_d = nivel_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      wr_en   = 1'b0;
      wr_idx  = sp_q;
      wr_data = push + AW'(RET_INC);

      if (pushsignal && popsignal && !empty) begin
         // tail replacement: return then call reuses the top slot
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (pushsignal) begin
         if (!full) begin
            wr_en   = 1'b1;
            sp_d    = sp_q + PW'(1);
            nivel_d = nivel_q + (PW+1)'(1);
         end else begin
            ovf_d = 1'b1;
`ifdef PILA_CIRCULAR_EN
            wr_en = 1'b1;
            sp_d  = sp_q + PW'(1);
`endif
         end
      end else if (popsignal) begin
         if (!empty) begin
            sp_d    = top_idx;
            nivel_d = nivel_q - (PW+1)'(1);
         end else begin
            udf_d = 1'b1;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q    <= '0;
         nivel_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         nivel_q <= nivel_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // NOTE: entry storage has no reset; nivel gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign pop               = empty ? '0 : mem_q[top_idx];
   assign vacia             = empty;
   assign llena             = full;
   assign nivel             = nivel_q;
   assign desbordamiento    = ovf_q;
   assign subdesbordamiento = udf_q;

endmodule

// File: tb/tb_pila_retorno.sv
// Directed self-checking bench for pila_retorno; expectations follow PILA_CIRCULAR_EN when defined.
module tb_pila_retorno;

   logic       clk = 1'b0;
   logic       reset;
   logic       popsignal, pushsignal;
   logic [9:0] push, pop;
   logic       vacia, llena, desbordamiento, subdesbordamiento;
   logic [3:0] nivel;

   int vec_cnt = 0;
   int err_cnt = 0;

   pila_retorno dut (
      .clk               (clk),
      .reset             (reset),
      .popsignal         (popsignal),
      .pushsignal        (pushsignal),
      .push              (push),
      .pop               (pop),
      .vacia             (vacia),
      .llena             (llena),
      .nivel             (nivel),
      .desbordamiento    (desbordamiento),
      .subdesbordamiento (subdesbordamiento)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one clock with the given controls, then return to idle just after the edge
   task automatic cyc(input logic ps, input logic pp, input logic [9:0] v);
      pushsignal = ps;
      popsignal  = pp;
      push       = v;
      @(posedge clk);
      #1;
      pushsignal = 1'b0;
      popsignal  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [9:0] exp_v;
      reset      = 1'b1;
      popsignal  = 1'b0;
      pushsignal = 1'b0;
      push       = '0;
      #12;
      check("rst_nivel", 16'(nivel), 16'd0);
      check("rst_vacia", 16'(vacia), 16'd1);
      check("rst_llena", 16'(llena), 16'd0);
      check("rst_ovf",   16'(desbordamiento), 16'd0);
      check("rst_udf",   16'(subdesbordamiento), 16'd0);
      check("rst_pop",   16'(pop), 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1: single push
      cyc(1'b1, 1'b0, 10'h010);
      check("t1_nivel", 16'(nivel), 16'd1);
      check("t1_vacia", 16'(vacia), 16'd0);
      check("t1_pop",   16'(pop), 16'h011);
      cyc(1'b0, 1'b1, 10'h000);
      check("t1_empty", 16'(nivel), 16'd0);

      // 2: LIFO order
      cyc(1'b1, 1'b0, 10'h020);
      cyc(1'b1, 1'b0, 10'h030);
      cyc(1'b1, 1'b0, 10'h040);
      check("t2_nivel3", 16'(nivel), 16'd3);
      for (int i = 0; i < 3; i++) begin
         exp_v = 10'h041 - 10'(i * 16);
         popsignal = 1'b1;
         #1;
         check("t2_pop", 16'(pop), 16'(exp_v));
         cyc(1'b0, 1'b1, 10'h000);
      end
      check("t2_nivel0", 16'(nivel), 16'd0);
      check("t2_vacia",  16'(vacia), 16'd1);

      // 3: underflow is sticky
      check("t3_udf_pre", 16'(subdesbordamiento), 16'd0);
      popsignal = 1'b1;
      #1;
      check("t3_pop_during", 16'(pop), 16'd0);
      cyc(1'b0, 1'b1, 10'h000);
      check("t3_udf",   16'(subdesbordamiento), 16'd1);
      check("t3_nivel", 16'(nivel), 16'd0);
      check("t3_pop",   16'(pop), 16'd0);
      repeat (5) cyc(1'b0, 1'b0, 10'h000);
      check("t3_udf_hold", 16'(subdesbordamiento), 16'd1);

      // 4: increment wraps
      cyc(1'b1, 1'b0, 10'h3FF);
      check("t4_pop",   16'(pop), 16'h000);
      check("t4_nivel", 16'(nivel), 16'd1);
      check("t4_vacia", 16'(vacia), 16'd0);

      do_reset();
      check("t3_udf_clr", 16'(subdesbordamiento), 16'd0);
      check("t4_rst_nivel", 16'(nivel), 16'd0);

      // 5: fill then push on full
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(i));
      check("t5_llena", 16'(llena), 16'd1);
      check("t5_nivel", 16'(nivel), 16'd8);
      check("t5_pop8",  16'(pop), 16'h008);
      check("t5_ovf0",  16'(desbordamiento), 16'd0);
      cyc(1'b1, 1'b0, 10'h100);
      check("t5_ovf",    16'(desbordamiento), 16'd1);
      check("t5_llena2", 16'(llena), 16'd1);
      check("t5_nivel2", 16'(nivel), 16'd8);
`ifdef PILA_CIRCULAR_EN
      check("t5_pop_ovf", 16'(pop), 16'h101);
`else
      check("t5_pop_ovf", 16'(pop), 16'h008);
`endif
      for (int i = 0; i < 8; i++) begin
`ifdef PILA_CIRCULAR_EN
         exp_v = (i == 0) ? 10'h101 : 10'(9 - i);
`else
         exp_v = 10'(8 - i);
`endif
         check("t5_drain", 16'(pop), 16'(exp_v));
         cyc(1'b0, 1'b1, 10'h000);
      end
      check("t5_vacia", 16'(vacia), 16'd1);
      check("t5_ovf_hold", 16'(desbordamiento), 16'd1);
      check("t5_udf", 16'(subdesbordamiento), 16'd0);

      // 6: tail replacement, both-on-empty, reset mid-cycle
      do_reset();
      check("t6_ovf_clr", 16'(desbordamiento), 16'd0);
      cyc(1'b1, 1'b1, 10'h070);
      check("t6_empty_both_nivel", 16'(nivel), 16'd1);
      check("t6_empty_both_pop",   16'(pop), 16'h071);
      check("t6_empty_both_udf",   16'(subdesbordamiento), 16'd0);
      cyc(1'b1, 1'b0, 10'h050);
      check("t6_nivel2", 16'(nivel), 16'd2);
      pushsignal = 1'b1;
      popsignal  = 1'b1;
      push       = 10'h060;
      #1;
      check("t6_pop_old", 16'(pop), 16'h051);
      cyc(1'b1, 1'b1, 10'h060);
      check("t6_pop_new", 16'(pop), 16'h061);
      check("t6_nivel_keep", 16'(nivel), 16'd2);
      cyc(1'b0, 1'b1, 10'h000);
      check("t6_under", 16'(pop), 16'h071);
      pushsignal = 1'b1;
      push       = 10'h080;
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_nivel", 16'(nivel), 16'd0);
      check("t6_rst_pop",   16'(pop), 16'd0);
      @(posedge clk);
      #1;
      check("t6_rst_abort", 16'(nivel), 16'd0);
      pushsignal = 1'b0;
      reset      = 1'b0;
      @(negedge clk);
      check("t6_post_vacia", 16'(vacia), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
